// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the accumulator control sequencer.
package acc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Datapath mux select values for SelB.
    localparam logic SEL_ABUS = 1'b0;
    localparam logic SEL_SUM  = 1'b1;

endpackage

// File: rtl/acc_sequencer.sv
// Sequences the 4-bit accumulator datapath through an N-operand summation job,
// pulling operands over a valid/ready handshake and pulsing done at the end.
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] op_count,
    input  logic             operand_valid,
    output logic             operand_ready,
    output logic             SelB,
    output logic             LoadAc,
    output logic             AddAlu,
    output logic             busy,
    output logic             done
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic             active;

    assign active = (state_reg == FIRST) || (state_reg == ACCUM);

    // Masking with rst keeps the datapath from loading on the reset edge.
    assign operand_ready = active & ~rst;
    assign LoadAc        = operand_valid & operand_ready;

    assign SelB   = (state_reg == ACCUM) ? SEL_SUM : SEL_ABUS;
    assign AddAlu = SelB;
    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    remaining_next = op_count;
                    state_next     = (op_count == '0) ? DONE : FIRST;
                end
            end
            FIRST, ACCUM: begin
                if (LoadAc) begin
                    if (remaining_reg != '0) begin
                        remaining_next = remaining_reg - CNT_W'(1);
                    end
                    // A count of 0 here can only come from corruption; finish rather than spin.
                    state_next = (remaining_reg <= CNT_W'(1)) ? DONE : ACCUM;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
